// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-period helper,
// frame constants. Imported by tx, baud_timer and the rx receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        ACK
    } tx_state_t;

    // Clocks per serial bit (integer division, truncating).
    function automatic int bit_cycles(int clk_freq, int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/baud_timer.sv
// Bit-period timer: free-running counter with synchronous clear and a
// one-cycle tick at terminal count BIT_CYCLES-1, after which it wraps to 0.
module baud_timer #(
    parameter int BIT_CYCLES = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM);

    // Count clocks within a bit; restart on clear or at the end of a bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/tx.sv
// UART transmitter: four-phase Send/Sent handshake, frame of start bit,
// 8 data bits LSB first, parity bit, stop bit. Sout connects straight to
// rx.Sin. Define TX_TWO_STOP_EN to stretch the stop bit to two bit periods.
// All outputs are registered from the current state, so the line lags the
// state register by one clock.
module tx
    import uart_pkg::*;
#(
    parameter int   CLK_FREQUENCY = 100_000_000,
    parameter int   BAUD_RATE     = 19_200,
    parameter logic PARITY        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Send,
    input  logic [7:0] Din,
    output logic       Sent,
    output logic       Busy,
    output logic       Sout
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q;
    logic [2:0] idx_q;
    logic       par_q;
    logic       tick, clr;
    logic       sout_d, sent_d, busy_d;
`ifdef TX_TWO_STOP_EN
    logic       stop2_q;
`endif

    // Counter only runs while a bit is on the wire.
    assign clr = (state_q == IDLE) || (state_q == ACK);

    baud_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: every bit phase advances on the timer tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (Send) state_d = START;
            START: if (tick) state_d = DATA;
            DATA:  if (tick && idx_q == LAST_BIT) state_d = PAR;
            PAR:   if (tick) state_d = STOP;
`ifdef TX_TWO_STOP_EN
            STOP:  if (tick && stop2_q) state_d = ACK;
`else
            STOP:  if (tick) state_d = ACK;
`endif
            ACK:   if (!Send) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the byte and its parity on acceptance; shift out one bit per tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
        end else if (state_q == IDLE && Send) begin
            shift_q <= Din;
            idx_q   <= '0;
            par_q   <= ^Din ^ PARITY;
        end else if (state_q == DATA && tick) begin
            shift_q <= shift_q >> 1;
            idx_q   <= idx_q + 3'd1;
        end
    end

`ifdef TX_TWO_STOP_EN
    // Marks that the first of the two stop periods has elapsed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stop2_q <= 1'b0;
        else if (state_q != STOP)
            stop2_q <= 1'b0;
        else if (tick)
            stop2_q <= 1'b1;
    end
`endif

    // Output decode from the current state.
    always_comb begin
        sout_d = 1'b1;
        sent_d = 1'b0;
        busy_d = (state_q != IDLE);
        unique case (state_q)
            START:   sout_d = 1'b0;
            DATA:    sout_d = shift_q[0];
            PAR:     sout_d = par_q;
            ACK:     sent_d = 1'b1;
            default: sout_d = 1'b1;
        endcase
    end

    // Registered outputs; Sout resets high so an abort never glitches low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Sout <= 1'b1;
            Sent <= 1'b0;
            Busy <= 1'b0;
        end else begin
            Sout <= sout_d;
            Sent <= sent_d;
            Busy <= busy_d;
        end
    end

endmodule

// File: tb/tb_tx.sv
// Self-checking bench for tx. Reduced clock/baud (BIT_CYCLES = 16) keeps
// frames short; the expected line is built from the frame rules directly.
module tb_tx;

    localparam int CLK_F = 160;
    localparam int BAUD  = 10;
    localparam int BC    = CLK_F / BAUD;
`ifdef TX_TWO_STOP_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif
    localparam int FLEN = NB * BC;
    localparam int BUF  = 2 * FLEN + 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Send = 1'b0;
    logic [7:0] Din = 8'h00;
    logic       Sent, Busy, Sout;

    int checks = 0;
    int errors = 0;

    logic sout_s [0:BUF];
    logic sent_s [0:BUF];
    logic busy_s [0:BUF];

    tx #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .PARITY(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .Send (Send),
        .Din  (Din),
        .Sent (Sent),
        .Busy (Busy),
        .Sout (Sout)
    );

    always #5 clk = ~clk;

    // Expected line level for bit period k of a frame carrying d (odd parity).
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return 1'b1;
    endfunction

    // Number of captured cycles of a frame (accepted at offset off) that deviate.
    function automatic int line_errs(input logic [7:0] d, input int off);
        int n = 0;
        for (int c = off + 1; c <= off + FLEN; c++)
            if (sout_s[c] !== exp_bit(d, (c - off - 1) / BC)) n++;
        return n;
    endfunction

    // Cycles from acceptance edge to first Sent high, -1 if never.
    function automatic int sent_rise(input int off);
        for (int c = off + 1; c <= BUF; c++)
            if (sent_s[c] === 1'b1) return c - off;
        return -1;
    endfunction

    function automatic int sent_len(input int off);
        int r = sent_rise(off);
        int n = 0;
        if (r < 0) return 0;
        for (int c = off + r; c <= BUF && sent_s[c] === 1'b1; c++) n++;
        return n;
    endfunction

    // Decode a byte from mid-bit samples, as a receiver would.
    function automatic logic [8:0] decode(input int off);
        logic [8:0] r = '0;
        for (int i = 0; i < 9; i++)
            r[i] = sout_s[off + 1 + (i + 1) * BC + BC / 2];
        return r;
    endfunction

    // Launch one request and record the outputs for len cycles after the
    // accepting edge. drop_at < 0: drop Send once Sent is seen.
    task automatic capture(input logic [7:0] d, input int len, input int drop_at,
                           input int chg_at, input logic reraise, input logic [7:0] d2);
        for (int c = 0; c <= BUF; c++) begin
            sout_s[c] = 1'bx; sent_s[c] = 1'bx; busy_s[c] = 1'bx;
        end
        @(posedge clk); #1;
        Send = 1'b1;
        Din  = d;
        @(posedge clk);
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            sout_s[c] = Sout;
            sent_s[c] = Sent;
            busy_s[c] = Busy;
            if (c == chg_at) Din = 8'h00;
            if (drop_at >= 0) begin
                if (c == drop_at) Send = 1'b0;
                if (reraise && c == drop_at + 1) begin
                    Send = 1'b1;
                    Din  = d2;
                end
            end else if (Sent) begin
                Send = 1'b0;
            end
        end
        Send = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst  = 1'b0;
        Send = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({Sout, Sent, Busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_values got %b%b%b want 100", Sout, Sent, Busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if ({Sout, Sent, Busy} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_hold got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_single_frame();
        logic [10:0] seq;
        int r, l;
        seq = 11'b10_0011_0111_0;  // stop, parity, d7..d0, start (bit k at index k)
        capture(8'h37, FLEN + 8, -1, -1, 1'b0, 8'h00);
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (sout_s[1 + k * BC + BC / 2] !== seq[k]) begin
                errors++;
                $display("FAIL frame37_bit%0d got %b want %b", k, sout_s[1 + k * BC + BC / 2], seq[k]);
            end
        end
        r = line_errs(8'h37, 0);
        checks++;
        if (r != 0) begin
            errors++;
            $display("FAIL frame37_width got %0d bad cycles want 0", r);
        end
        r = sent_rise(0);
        checks++;
        if (r != FLEN + 1) begin
            errors++;
            $display("FAIL frame37_sent_rise got %0d want %0d", r, FLEN + 1);
        end
        l = sent_len(0);
        checks++;
        if (l != 2) begin
            errors++;
            $display("FAIL frame37_sent_len got %0d want 2", l);
        end
        checks++;
        if ({busy_s[1], busy_s[FLEN + 2], busy_s[FLEN + 3], sent_s[FLEN + 3]} !== 4'b1100) begin
            errors++;
            $display("FAIL frame37_busy got %b%b%b%b want 1100",
                     busy_s[1], busy_s[FLEN + 2], busy_s[FLEN + 3], sent_s[FLEN + 3]);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] vals [16];
        logic [8:0] got;
        int r;
        vals[0] = 8'hff; vals[1] = 8'h00; vals[2] = 8'h0f; vals[3] = 8'hf0;
        vals[4] = 8'h37; vals[5] = 8'h73; vals[6] = 8'haa; vals[7] = 8'h55;
        for (int i = 8; i < 16; i++) vals[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) begin
            capture(vals[i], FLEN + 8, -1, -1, 1'b0, 8'h00);
            got = decode(0);
            checks++;
            if (got[7:0] !== vals[i] || ($countones(got) % 2) != 1) begin
                errors++;
                $display("FAIL loopback_%0d got %h par %b want %h odd parity",
                         i, got[7:0], got[8], vals[i]);
            end
            r = line_errs(vals[i], 0);
            checks++;
            if (r != 0) begin
                errors++;
                $display("FAIL loopback_line_%0d got %0d bad cycles want 0", i, r);
            end
        end
    endtask

    task automatic test_din_change();
        logic [8:0] got;
        capture(8'haa, FLEN + 8, -1, 1, 1'b0, 8'h00);
        got = decode(0);
        checks++;
        if (got[7:0] !== 8'haa || line_errs(8'haa, 0) != 0) begin
            errors++;
            $display("FAIL din_change got %h want aa", got[7:0]);
        end
    endtask

    task automatic test_send_drop();
        logic [7:0] d;
        int r, l;
        d = 8'($urandom_range(0, 255));
        capture(d, FLEN + 8, 1 + 3 * BC + BC / 2, -1, 1'b0, 8'h00);
        r = line_errs(d, 0);
        checks++;
        if (r != 0) begin
            errors++;
            $display("FAIL drop_line got %0d bad cycles want 0", r);
        end
        r = sent_rise(0);
        l = sent_len(0);
        checks++;
        if (r != FLEN + 1 || l != 1) begin
            errors++;
            $display("FAIL drop_sent got rise %0d len %0d want rise %0d len 1", r, l, FLEN + 1);
        end
        checks++;
        if ({busy_s[FLEN + 2], sout_s[FLEN + 2], sout_s[FLEN + 8]} !== 3'b011) begin
            errors++;
            $display("FAIL drop_idle got %b%b%b want 011",
                     busy_s[FLEN + 2], sout_s[FLEN + 2], sout_s[FLEN + 8]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        int r1, r2, l;
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        capture(d1, 2 * FLEN + 10, FLEN, -1, 1'b1, d2);
        r1 = line_errs(d1, 0);
        r2 = line_errs(d2, FLEN + 2);
        checks++;
        if (r1 != 0 || r2 != 0) begin
            errors++;
            $display("FAIL b2b_lines got %0d/%0d bad cycles want 0/0", r1, r2);
        end
        l = sent_len(0);
        r2 = sent_rise(FLEN + 2);
        checks++;
        if (l != 1 || r2 != FLEN + 1) begin
            errors++;
            $display("FAIL b2b_sent got len %0d rise2 %0d want len 1 rise2 %0d", l, r2, FLEN + 1);
        end
        checks++;
        if ({sout_s[FLEN + 1], sout_s[FLEN + 2], busy_s[FLEN + 2], busy_s[FLEN + 3]} !== 4'b1101) begin
            errors++;
            $display("FAIL b2b_gap got %b%b%b%b want 1101",
                     sout_s[FLEN + 1], sout_s[FLEN + 2], busy_s[FLEN + 2], busy_s[FLEN + 3]);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(posedge clk); #1;
        Send = 1'b1;
        Din  = 8'h00;
        @(posedge clk);
        repeat (BC + BC / 2) @(posedge clk);
        #1;
        checks++;
        if (Sout !== 1'b0) begin
            errors++;
            $display("FAIL mid_data_low got %b want 0", Sout);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({Sout, Sent, Busy} !== 3'b100) begin
            errors++;
            $display("FAIL async_abort got %b%b%b want 100", Sout, Sent, Busy);
        end
        Send = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3 * FLEN; i++) begin
            @(posedge clk); #1;
            if ({Sout, Sent, Busy} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_abort_idle got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_loopback();
        test_din_change();
        test_send_drop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx.md
# tx

UART transmitter that sits directly upstream of the `rx` receiver and drives its `Sin` line. It accepts a byte over a four-phase `Send`/`Sent` handshake and serializes it on `Sout` as one frame: start bit, 8 data bits LSB first, parity bit, stop bit. Frame format and bit timing match `rx` exactly, so `tx.Sout` connects straight to `rx.Sin` for loopback benches and board bring-up.

## Interface
- `CLK_FREQUENCY`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 19_200: serial bit rate.
- `PARITY`, default 1'd1: parity sense.
  - 1 = odd parity.
  - 0 = even parity.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-low.
- `Send` input, 1 bit: request to transmit `Din`.
- `Din` input, 8 bits: byte to transmit; sampled only when a request is accepted.
- `Sent` output, 1 bit: frame complete (acknowledge for `Send`).
- `Busy` output, 1 bit: high from acceptance until the FSM returns to IDLE.
- `Sout` output, 1 bit: serial line; idles high.

## Operation
- Bit period: BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE, using integer division.
- Baud counter:
  - Width is $clog2(BIT_CYCLES).
  - Cleared on every state or bit transition.
  - Terminal count is BIT_CYCLES-1.
- Parity bit value: ^data ^ PARITY.
- FSM states:
  - IDLE: `Sout`=1, `Busy`=0, `Sent`=0.
    - When `Send`=1: latch `Din` into a shift register, clear the counter and bit index, go to START.
  - START: `Sout`=0 for BIT_CYCLES cycles, then go to DATA.
  - DATA: `Sout`=shift[0] for BIT_CYCLES cycles per bit.
    - After each bit, shift right and increment the 3-bit index.
    - After bit 7 (index wrap to 0), go to PAR.
  - PAR: `Sout`=parity bit for BIT_CYCLES cycles, then go to STOP.
  - STOP: `Sout`=1 for BIT_CYCLES cycles, then go to ACK.
  - ACK: `Sout`=1, `Sent`=1. When `Send`=0, go to IDLE.
- `Busy`=1 in every state except IDLE.
- `Din` changes after acceptance are ignored; the latched copy is transmitted.
- `Send` dropped before ACK:
  - The frame still completes.
  - ACK is then held for exactly one cycle.
  - Exit to IDLE follows.
- `Send` still high when IDLE is re-entered: a new frame starts the following cycle. Back-to-back frames are legal.
- Reset asserted mid-frame: all state aborts immediately and asynchronously, and `Sout` returns high with no glitch low.

## Timing
- Reset values:
  - `Sout`=1, `Sent`=0, `Busy`=0.
  - State = IDLE, counter = 0, shift register = 0.
- All outputs are registered.
- `Sout` falls on the clock edge after the edge that samples `Send`=1 in IDLE. This is 1 cycle of latency.
- Each serial bit lasts exactly BIT_CYCLES clocks.
- The frame occupies 11 × BIT_CYCLES clocks (start, 8 data, parity, stop).
- `Sent` rises on the edge that ends the stop bit.
- `Sent` falls on the edge after `Send` is sampled low.
- `Busy` falls in the same cycle as `Sent`.
- Minimum spacing between frame start edges is 11 × BIT_CYCLES + 2 clocks.

## Configuration
- Macro: `TX_TWO_STOP_EN`.
- Defined:
  - STOP lasts 2 × BIT_CYCLES.
  - The frame is 12 bit periods.
  - Remaining timing shifts accordingly.
- Undefined: one stop bit, exactly as described above.
- `rx` accepts both variants, because extra idle-high time is legal.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PAR, STOP, ACK).
  - `function automatic int bit_cycles(int clk_freq, int baud)`.
  - Frame constants: `DATA_BITS`=8.
  - `rx` imports the same package.
- One natural sub-module: `baud_timer`.
  - Parameterized by BIT_CYCLES.
  - Inputs: `clk`, `rst`, `clr`.
  - Output: `tick`, a one-cycle pulse at terminal count.
  - The FSM advances on `tick`.

## Test plan
- Reset/idle: hold `rst`=0 for 2 cycles, then release; `Send`=0 -> `Sout`=1, `Sent`=0, `Busy`=0 for 100 cycles.
- Single frame, `Din`=8'h37, PARITY=1 -> sample `Sout` mid-bit:
  - Line sequence 0, 1,1,1,0,1,1,0,0, 0 (parity), 1 (stop).
  - Each bit is 5208 clocks wide at defaults.
  - `Sent` rises 11 × 5208 + 1 cycles after `Send` is sampled.
- Loopback into `rx`: send 8'hff, 00, 0f, f0, 37, 73, aa, 55 -> `rx.Dout` matches each byte and `parityErr`=0 throughout.
- `Din` changed to 8'h00 one cycle after acceptance of 8'haa -> line still carries 8'haa.
- `Send` dropped at the middle of bit 3 -> frame completes, `Sent` is high for 1 cycle, then IDLE.
- Reset asserted mid-DATA with `Sout`=0 -> `Sout`=1 before the next clock edge; no further frame activity after release.
